// File: rtl/vga_pixel_mux.sv
// vga_pixel_mux: final video stage. Composites the sprite renderer output over a
// sky/floor background, delays sync/blank to match the sprite ROM pipeline and
// expands RRRGGGBB to 8 bits per DAC channel.
//
// Optional feature macro: HIT_FLASH_EN. When defined, a hit_pulse starts a
// FLASH_FRAMES-long counter and visible sprite pixels blink white on odd counts.
//
// Flow control: there is no handshake. One pixel is accepted and one pixel is
// produced every clock; outputs follow inputs by three clock edges.
module vga_pixel_mux #(
    parameter logic [9:0] FLOOR_Y      = 10'd400,
    parameter logic [7:0] SKY_COLOR    = 8'b0101_1011,
    parameter logic [7:0] FLOOR_COLOR  = 8'b0110_0100,
    parameter logic [3:0] FLASH_FRAMES = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       video_on_in,
    input  logic       sprite_visible,
    input  logic [7:0] sprite_data,
    input  logic       hit_pulse,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       frame_start
);

    // Replicate each colour field's bits so 0 stays 0 and full scale is all-ones.
    function automatic logic [23:0] expand(input logic [7:0] c);
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        r = c[7:5];
        g = c[4:2];
        b = c[1:0];
        expand = {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
    endfunction

    logic [7:0] bg_s0;
    logic       sof_s0;

    logic [7:0] bg_s1;
    logic       hs_s1;
    logic       vs_s1;
    logic       von_s1;
    logic       sof_s1;

    logic [7:0] bg_s2;
    logic       hs_s2;
    logic       vs_s2;
    logic       von_s2;
    logic       sof_s2;

    logic       flash_on;
    logic [7:0] pix_c;

    // Stage 0: background colour from the row and start-of-frame detect.
    always_comb begin
        bg_s0  = (pixel_y >= FLOOR_Y) ? FLOOR_COLOR : SKY_COLOR;
        sof_s0 = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    end

    // Stages 1-2: two-deep delay so timing signals line up with the sprite data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_s1  <= 8'h00;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            von_s1 <= 1'b0;
            sof_s1 <= 1'b0;
            bg_s2  <= 8'h00;
            hs_s2  <= 1'b1;
            vs_s2  <= 1'b1;
            von_s2 <= 1'b0;
            sof_s2 <= 1'b0;
        end else begin
            bg_s1  <= bg_s0;
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
            von_s1 <= video_on_in;
            sof_s1 <= sof_s0;
            bg_s2  <= bg_s1;
            hs_s2  <= hs_s1;
            vs_s2  <= vs_s1;
            von_s2 <= von_s1;
            sof_s2 <= sof_s1;
        end
    end

`ifdef HIT_FLASH_EN
    logic [3:0] flash_cnt;

    // Flash counter: a hit (re)loads it, each start of frame counts it down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt <= 4'd0;
        end else if (hit_pulse) begin
            flash_cnt <= FLASH_FRAMES;
        end else if (sof_s0 && (flash_cnt != 4'd0)) begin
            flash_cnt <= flash_cnt - 4'd1;
        end
    end

    // Blink on odd counts so the sprite alternates white/normal per frame.
    always_comb begin
        flash_on = (flash_cnt != 4'd0) && flash_cnt[0];
    end
`else
    logic unused_hit;

    // Without the flash feature the hit request has no effect.
    always_comb begin
        unused_hit = hit_pulse;
        flash_on   = 1'b0;
    end
`endif

    // Colour priority: blanking, then white flash, then sprite, then background.
    always_comb begin
        pix_c = bg_s2;
        if (!von_s2) begin
            pix_c = 8'h00;
        end else if (sprite_visible && flash_on) begin
            pix_c = 8'hFF;
        end else if (sprite_visible) begin
            pix_c = sprite_data;
        end
    end

    // Stage 3: output register for RGB, syncs, blank and frame marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            {vga_r, vga_g, vga_b} <= expand(pix_c);
            vga_hs                <= hs_s2;
            vga_vs                <= vs_s2;
            vga_blank_n           <= von_s2;
            frame_start           <= sof_s2;
        end
    end

endmodule

// File: doc/vga_pixel_mux.md
# vga_pixel_mux

- Final stage of the video path; sits directly downstream of the sprite ROM renderer.
- Takes the renderer's per-pixel sprite colour and visibility flag and composites them over a procedurally generated sky/floor background.
- Delays the VGA sync and blanking signals so they stay aligned with the sprite ROM pipeline.
- Expands 8-bit RRRGGGBB colour to 8-bit-per-channel DAC outputs and optionally flashes sprites white after a hit.

## Interface

Parameters:
- FLOOR_Y, 10'd400: first pixel row drawn in floor colour.
- SKY_COLOR, 8'b0101_1011: RRRGGGBB background above FLOOR_Y.
- FLOOR_COLOR, 8'b0110_0100: RRRGGGBB background at and below FLOOR_Y.
- FLASH_FRAMES, 4'd8: frames a hit flash lasts.

Ports:
- clk, input, 1: pixel clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- pixel_x, input, 10: current pixel column from the timing generator.
- pixel_y, input, 10: current pixel row from the timing generator.
- hsync_in, input, 1: horizontal sync, aligned with pixel_x/pixel_y.
- vsync_in, input, 1: vertical sync, aligned with pixel_x/pixel_y.
- video_on_in, input, 1: active-area flag, aligned with pixel_x/pixel_y.
- sprite_visible, input, 1: renderer visibility flag; refers to coordinates presented 2 cycles earlier.
- sprite_data, input, 8: renderer RRRGGGBB colour; same alignment as sprite_visible.
- hit_pulse, input, 1: single-cycle request to start a hit flash.
- vga_r, output, 8: red channel to the DAC.
- vga_g, output, 8: green channel to the DAC.
- vga_b, output, 8: blue channel to the DAC.
- vga_hs, output, 1: delayed horizontal sync.
- vga_vs, output, 1: delayed vertical sync.
- vga_blank_n, output, 1: low outside the active area.
- frame_start, output, 1: one-cycle pulse marking the first output pixel of a frame.

## Operation

- **Stage 0 (cycle t):** compute bg = (pixel_y >= FLOOR_Y) ? FLOOR_COLOR : SKY_COLOR. Detect sof0 = (pixel_x==0 && pixel_y==0).
- **Stages 1–2:** shift-register delay of {bg, hsync_in, vsync_in, video_on_in, sof0}, two deep. At cycle t+2 these values line up with sprite_visible/sprite_data.
- **Stage 3 (output register):** select the colour in this priority order:
  1. Delayed video_on = 0 → colour 0.
  2. sprite_visible = 1 and flash active → 8'hFF (white).
  3. sprite_visible = 1 → sprite_data.
  4. Otherwise → delayed bg.
- **Colour expansion**, for c = {r[2:0], g[2:0], b[1:0]}:
  - vga_r = {r, r, r[2:1]}
  - vga_g = {g, g, g[2:1]}
  - vga_b = {b, b, b, b}
  - 0 maps to 0; 8'hFF maps to all-ones.
- **Sync and flags:** vga_hs, vga_vs and vga_blank_n are the stage-2 sync and video_on values, registered alongside the RGB. frame_start is the delayed sof0, registered alongside the RGB.
- **Flash counter** (4-bit flash_cnt, only when compiled in):
  - hit_pulse loads FLASH_FRAMES.
  - Otherwise, sof0 with flash_cnt != 0 decrements it.
  - Flash is active when flash_cnt != 0 and flash_cnt[0] = 1, so sprites blink every other frame.
  - hit_pulse in the same cycle as sof0: the load wins and no decrement happens.
  - hit_pulse during an active flash restarts it at FLASH_FRAMES.
  - flash_cnt saturates at 0.
  - The flash colour applies only to sprite-visible pixels; the background is never altered.

## Timing

- Latency: pixel_x/pixel_y/syncs at cycle t appear on the outputs after the clock edge ending cycle t+2, i.e. visible during t+3.
- Throughput: one pixel per clock, no stalls, no handshake.
- Reset (rst_n low, asynchronous):
  - vga_r, vga_g, vga_b = 0
  - vga_hs = 1, vga_vs = 1
  - vga_blank_n = 0
  - frame_start = 0
  - all delay stages cleared (syncs 1, video_on 0, bg 0, sof 0)
  - flash_cnt = 0
- Release is synchronous to the next clk edge. The first valid output pixel appears 3 cycles after the first sampled input.
- Reset asserted mid-line or mid-flash: outputs go to reset values immediately and the flash is cancelled.
- Polarity of sync outputs equals that of the inputs; this block performs no inversion.

## Configuration

- HIT_FLASH_EN defined: flash_cnt and the white-override path are built as described.
- HIT_FLASH_EN undefined: no counter, hit_pulse is ignored, and visible sprite pixels always output sprite_data. Latency and all other behaviour are unchanged.

## Test plan

- **Reset values:** assert rst_n=0 mid-frame.
  - Outputs immediately read RGB 0, hs=1, vs=1, blank_n=0, frame_start=0.
  - After release, the first three cycles show flushed (reset) pipeline values.
- **Background split:** drive video_on_in=1 and sprite_visible=0.
  - pixel_y=399 → vga_r/g/b = expand(8'b0101_1011), 3 cycles later.
  - pixel_y=400 → expand(8'b0110_0100).
- **Sprite overlay and alignment:** sprite_visible=1 and sprite_data=8'b1110_0000 presented 2 cycles after coords (100,100).
  - Output RGB = FF/00/00 on the same cycle as the delayed syncs for (100,100).
  - sprite_visible=0 on the next pixel → background colour.
- **Blanking precedence:** video_on_in=0 with sprite_visible=1 and sprite_data=8'hFF.
  - RGB = 0 and vga_blank_n = 0.
  - hsync_in pattern appears on vga_hs delayed exactly 3 cycles.
- **Flash sequence (HIT_FLASH_EN):** hit_pulse once, then run 10 frames.
  - flash_cnt = 8 gives no flash; the counter then decrements each frame to 0.
  - Flash active (white on visible sprite pixels) while flash_cnt ∈ {7,5,3,1}.
  - A second hit_pulse coincident with sof0 reloads the counter to 8 with no decrement.
- **Flash compiled out:** hit_pulse asserted repeatedly.
  - Sprite pixels always equal the expanded sprite_data.
  - frame_start pulses once per frame at output pixel (0,0).
